// File: rtl/decimal_value_entry_pkg.sv
// ---------------------------------------------------------------------------
// decimal_value_entry_pkg
// Shared types and constants for the decimal keystroke entry block.
//   de_state_t      : controller states
//   de_digit_buf_t  : packed digit buffer at the default depth, [0] = LS digit
//   DE_BASE         : decimal base used for digit legality
//   POWERS_OF_10    : 10^n table, used to derive the largest enterable value
// ---------------------------------------------------------------------------
package decimal_value_entry_pkg;

  typedef enum logic [2:0] {
    DE_IDLE,
    DE_EDIT,
    DE_CONVERT,
    DE_CHECK,
    DE_DONE
  } de_state_t;

  localparam int DE_BASE               = 10;
  localparam int DE_DIGIT_W            = 4;
  localparam int DE_MAX_DIGITS_DEFAULT = 2;

  typedef logic [DE_MAX_DIGITS_DEFAULT-1:0][DE_DIGIT_W-1:0] de_digit_buf_t;

  // 10^n for every legal buffer depth (0..4).
  localparam int unsigned POWERS_OF_10 [5] = '{1, 10, 100, 1000, 10000};

endpackage

// File: rtl/decimal_value_entry_mac.sv
// ---------------------------------------------------------------------------
// dec_mac_sat
// Combinational multiply-accumulate step for decimal-to-binary conversion:
// result = acc*10 + d, built from shifts, saturating at all-ones.
// Ports:
//   acc    in  W   running accumulator
//   d      in  4   next digit (0..9)
//   result out W   acc*10+d, or all-ones when saturated
//   sat    out 1   set when the true result does not fit in W bits
// ---------------------------------------------------------------------------
module dec_mac_sat
  import decimal_value_entry_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0]          acc,
  input  logic [DE_DIGIT_W-1:0] d,
  output logic [W-1:0]          result,
  output logic                  sat
);

  // Four guard bits hold acc*10+9 without wrapping.
  logic [W+3:0] wide;

  always_comb begin
    wide   = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{W{1'b0}}, d};
    // An already-saturated accumulator stays saturated.
    sat    = (acc == {W{1'b1}}) || (wide[W+3:W] != 4'b0000);
    result = sat ? {W{1'b1}} : wide[W-1:0];
  end

endmodule

// File: rtl/decimal_value_entry.sv
// ---------------------------------------------------------------------------
// decimal_value_entry
// Turns decimal keystrokes (digits, backspace, enter, cancel) into a clamped
// binary option value. Digits are converted serially, MS digit first, one
// per clock, then range-checked against [min_value, max_value].
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   start            open an edit session (IDLE only)
//   cur_value        returned when enter is pressed with an empty buffer
//   min_value        inclusive lower clamp
//   max_value        inclusive upper clamp (wins if min_value > max_value)
//   digit_valid,digit  digit strobe and code (0..9 legal)
//   backspace, enter, cancel  editing controls, priority cancel>enter>bs>digit
//   editing          high in EDIT
//   busy             high in CONVERT/CHECK
//   digits_out       live buffer, [0] = least significant, unused slots 0
//   digit_count      digits held
//   value_out        committed value, held until next commit
//   value_valid      one-cycle commit pulse
//   range_err        clamping occurred on the last commit
//   cancelled        one-cycle abort pulse
// Build option: DIGIT_ENTRY_AUTOCOMMIT_EN - filling the buffer starts the
// conversion immediately; only cancel is honoured in the first CONVERT cycle.
// ---------------------------------------------------------------------------
module decimal_value_entry
  import decimal_value_entry_pkg::*;
#(
  parameter int W_OUT      = 8,
  parameter int MAX_DIGITS = DE_MAX_DIGITS_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [W_OUT-1:0]                     cur_value,
  input  logic [W_OUT-1:0]                     min_value,
  input  logic [W_OUT-1:0]                     max_value,
  input  logic                                 digit_valid,
  input  logic [DE_DIGIT_W-1:0]                digit,
  input  logic                                 backspace,
  input  logic                                 enter,
  input  logic                                 cancel,
  output logic                                 editing,
  output logic                                 busy,
  output logic [MAX_DIGITS-1:0][DE_DIGIT_W-1:0] digits_out,
  output logic [2:0]                           digit_count,
  output logic [W_OUT-1:0]                     value_out,
  output logic                                 value_valid,
  output logic                                 range_err,
  output logic                                 cancelled
);

`ifdef DIGIT_ENTRY_AUTOCOMMIT_EN
  localparam bit AUTOCOMMIT = 1'b1;
`else
  localparam bit AUTOCOMMIT = 1'b0;
`endif

  localparam int ACC_W = W_OUT + 1;
  localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  // Saturation can only happen if the largest enterable number overflows
  // the accumulator; otherwise the sticky flag is irrelevant.
  localparam int unsigned     MAX_ENTRY    = POWERS_OF_10[MAX_DIGITS] - 1;
  localparam longint unsigned ACC_ALL_ONES = (64'd1 << ACC_W) - 64'd1;
  localparam bit              CAN_SAT      = (64'(MAX_ENTRY) > ACC_ALL_ONES);

  typedef logic [MAX_DIGITS-1:0][DE_DIGIT_W-1:0] digit_buf_t;

  de_state_t        state_reg;
  digit_buf_t       buf_reg;
  digit_buf_t       buf_up;
  digit_buf_t       buf_down;
  logic [2:0]       count_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             sat_reg;
  logic [W_OUT-1:0] result_reg;
  logic             result_err_reg;
  logic             auto_first_reg;
  logic [ACC_W-1:0] mac_result;
  logic             mac_sat;
  logic             digit_ok;

  // Shift-in (new digit at [0]) and shift-out (top slot zeroed) views.
  for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_shift
    if (gi == 0) begin : g_lo
      assign buf_up[gi] = digit;
    end else begin : g_hi
      assign buf_up[gi] = buf_reg[gi-1];
    end
    if (gi == MAX_DIGITS - 1) begin : g_top
      assign buf_down[gi] = '0;
    end else begin : g_mid
      assign buf_down[gi] = buf_reg[gi+1];
    end
  end

  assign digit_ok = digit_valid && (digit < 4'(DE_BASE)) &&
                    (count_reg < 3'(MAX_DIGITS));

  dec_mac_sat #(.W(ACC_W)) u_mac (
    .acc    (acc_reg),
    .d      (buf_reg[idx_reg]),
    .result (mac_result),
    .sat    (mac_sat)
  );

  assign digits_out  = buf_reg;
  assign digit_count = count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= DE_IDLE;
      buf_reg        <= '0;
      count_reg      <= '0;
      idx_reg        <= '0;
      acc_reg        <= '0;
      sat_reg        <= 1'b0;
      result_reg     <= '0;
      result_err_reg <= 1'b0;
      auto_first_reg <= 1'b0;
      editing        <= 1'b0;
      busy           <= 1'b0;
      value_out      <= '0;
      value_valid    <= 1'b0;
      range_err      <= 1'b0;
      cancelled      <= 1'b0;
    end else begin
      value_valid    <= 1'b0;
      cancelled      <= 1'b0;
      auto_first_reg <= 1'b0;
      case (state_reg)
        DE_IDLE: begin
          if (start) begin
            state_reg <= DE_EDIT;
            buf_reg   <= '0;
            count_reg <= '0;
            editing   <= 1'b1;
          end
        end

        DE_EDIT: begin
          if (cancel) begin
            state_reg <= DE_IDLE;
            editing   <= 1'b0;
            cancelled <= 1'b1;
          end else if (enter) begin
            // Empty buffer skips conversion but keeps the same latency path.
            state_reg <= (count_reg != 3'd0) ? DE_CONVERT : DE_CHECK;
            editing   <= 1'b0;
            busy      <= 1'b1;
            acc_reg   <= '0;
            sat_reg   <= 1'b0;
            idx_reg   <= IDX_W'(count_reg - 3'd1);
          end else if (backspace) begin
            if (count_reg != 3'd0) begin
              buf_reg   <= buf_down;
              count_reg <= count_reg - 3'd1;
            end
          end else if (digit_ok) begin
            buf_reg   <= buf_up;
            count_reg <= count_reg + 3'd1;
            if (AUTOCOMMIT && (count_reg == 3'(MAX_DIGITS - 1))) begin
              state_reg      <= DE_CONVERT;
              editing        <= 1'b0;
              busy           <= 1'b1;
              acc_reg        <= '0;
              sat_reg        <= 1'b0;
              idx_reg        <= IDX_W'(MAX_DIGITS - 1);
              auto_first_reg <= 1'b1;
            end
          end
        end

        DE_CONVERT: begin
          if (auto_first_reg && cancel) begin
            // An implicit commit can still be aborted in its first cycle.
            state_reg <= DE_IDLE;
            busy      <= 1'b0;
            cancelled <= 1'b1;
          end else begin
            acc_reg <= mac_result;
            sat_reg <= sat_reg | mac_sat;
            if (idx_reg == '0) begin
              state_reg <= DE_CHECK;
            end else begin
              idx_reg <= idx_reg - IDX_W'(1);
            end
          end
        end

        DE_CHECK: begin
          busy      <= 1'b0;
          state_reg <= DE_DONE;
          if (count_reg == 3'd0) begin
            result_reg     <= cur_value;
            result_err_reg <= 1'b0;
          end else if ((CAN_SAT && sat_reg) || (acc_reg > {1'b0, max_value}) ||
                       (min_value > max_value)) begin
            // The upper clamp is tested first so an empty range yields max.
            result_reg     <= max_value;
            result_err_reg <= 1'b1;
          end else if (acc_reg < {1'b0, min_value}) begin
            result_reg     <= min_value;
            result_err_reg <= 1'b1;
          end else begin
            result_reg     <= acc_reg[W_OUT-1:0];
            result_err_reg <= 1'b0;
          end
        end

        DE_DONE: begin
          value_out   <= result_reg;
          range_err   <= result_err_reg;
          value_valid <= 1'b1;
          state_reg   <= DE_IDLE;
        end

        default: begin
          state_reg <= DE_IDLE;
          editing   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_value_entry.sv
module tb_decimal_value_entry;

  localparam int MAXD = 2;

  logic                 clk;
  logic                 reset_n;
  logic                 start;
  logic [7:0]           cur_value, min_value, max_value;
  logic                 digit_valid;
  logic [3:0]           digit;
  logic                 backspace, enter, cancel;
  logic                 editing, busy;
  logic [MAXD-1:0][3:0] digits_out;
  logic [2:0]           digit_count;
  logic [7:0]           value_out;
  logic                 value_valid, range_err, cancelled;

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];             // model buffer, most significant digit first
  int last_val = 0;
  bit last_err = 1'b0;

  decimal_value_entry #(.W_OUT(8), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cur_value(cur_value),
    .min_value(min_value), .max_value(max_value), .digit_valid(digit_valid),
    .digit(digit), .backspace(backspace), .enter(enter), .cancel(cancel),
    .editing(editing), .busy(busy), .digits_out(digits_out),
    .digit_count(digit_count), .value_out(value_out), .value_valid(value_valid),
    .range_err(range_err), .cancelled(cancelled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; digit_valid = 0; digit = 0; backspace = 0; enter = 0; cancel = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_digits();
    logic [MAXD-1:0][3:0] e;
    e = '0;
    for (int i = 0; i < q.size(); i++) e[i] = 4'(q[q.size()-1-i]);
    return e;
  endfunction

  task automatic model_digit(input int d);
    if (d <= 9 && q.size() < MAXD) q.push_back(d);
  endtask

  task automatic model_bs();
    if (q.size() > 0) void'(q.pop_back());
  endtask

  task automatic model_result(output int v, output bit e);
    int acc;
    acc = 0;
    foreach (q[i]) acc = acc * 10 + q[i];
    if (q.size() == 0)                begin v = cur_value; e = 0; end
    else if (min_value > max_value)   begin v = max_value; e = 1; end
    else if (acc > int'(max_value))   begin v = max_value; e = 1; end
    else if (acc < int'(min_value))   begin v = min_value; e = 1; end
    else                              begin v = acc;       e = 0; end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic begin_session();
    start = 1; cyc(); start = 0;
    q.delete();
  endtask

  task automatic key_digit(input int d);
    digit_valid = 1; digit = 4'(d); cyc(); digit_valid = 0;
    model_digit(d);
  endtask

  task automatic key_bs();
    backspace = 1; cyc(); backspace = 0;
    model_bs();
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (value_valid === 1'b1) begin lat = n; break; end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " editing"}, editing, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " digits_out"}, digits_out, 0);
    chk({tag, " digit_count"}, digit_count, 0);
    chk({tag, " value_out"}, value_out, 0);
    chk({tag, " value_valid"}, value_valid, 0);
    chk({tag, " range_err"}, range_err, 0);
    chk({tag, " cancelled"}, cancelled, 0);
  endtask

  // Pulses enter (other inputs left as the caller set them) and checks result.
  task automatic commit_and_check(input string tag, input int ev, input bit ee);
    int lat;
    int n;
    n = q.size();
    enter = 1; cyc(); idle_inputs();
    chk({tag, " busy"}, busy, 1);
    wait_valid(lat);
    chk({tag, " latency"}, lat, n + 2);
    chk({tag, " value_out"}, value_out, ev);
    chk({tag, " range_err"}, range_err, ee);
    cyc();
    chk({tag, " valid pulse width"}, value_valid, 0);
    last_val = ev; last_err = ee;
    $display("[TB] commit %s: digits=%0d min=%0d max=%0d cur=%0d -> value=%0d err=%0d latency=%0d",
             tag, n, min_value, max_value, cur_value, value_out, range_err, lat);
  endtask

  task automatic cancel_and_check(input string tag);
    cancel = 1; cyc(); idle_inputs();
    chk({tag, " cancelled"}, cancelled, 1);
    chk({tag, " editing"}, editing, 0);
    chk({tag, " value_out kept"}, value_out, last_val);
    chk({tag, " range_err kept"}, range_err, last_err);
    cyc();
    chk({tag, " cancel pulse width"}, cancelled, 0);
    $display("[TB] cancel %s: value_out=%0d", tag, value_out);
  endtask

  typedef struct {
    int n;
    int d[3];
    int ev;
    bit ee;
  } vec_t;

  function automatic vec_t mk(input int n, input int a, input int b, input int c,
                              input int ev, input bit ee);
    vec_t v;
    v.n = n; v.d[0] = a; v.d[1] = b; v.d[2] = c; v.ev = ev; v.ee = ee;
    return v;
  endfunction

  vec_t tbl [9];
  int   lat_i, ev_i, seen;
  bit   ee_i, done, cn, en, bs, dv;
  int   dd;

  initial begin
    idle_inputs();
    cur_value = 8'd6; min_value = 8'd1; max_value = 8'd21;
    reset_n = 0;
    cyc(); cyc();
    check_reset_state("reset");
    $display("[TB] reset applied");
    reset_n = 1;
    cyc();

`ifndef DIGIT_ENTRY_AUTOCOMMIT_EN
    // Plain commit with live echo.
    begin_session();
    chk("session editing", editing, 1);
    key_digit(1); key_digit(5);
    chk("echo digits_out", digits_out, 8'h15);
    chk("echo digit_count", digit_count, 2);
    commit_and_check("plain", 15, 0);

    // Table of single-session vectors at min=1 max=21 cur=6.
    tbl[0] = mk(2, 1, 5, 0, 15, 0);
    tbl[1] = mk(3, 9, 9, 3, 21, 1);   // third digit dropped, clamp high
    tbl[2] = mk(1, 0, 0, 0, 1, 1);    // clamp low
    tbl[3] = mk(0, 0, 0, 0, 6, 0);    // empty -> cur_value
    tbl[4] = mk(2, 2, 1, 0, 21, 0);   // exactly max
    tbl[5] = mk(1, 1, 0, 0, 1, 0);    // exactly min
    tbl[6] = mk(2, 2, 2, 0, 21, 1);   // max+1
    tbl[7] = mk(2, 11, 3, 0, 3, 0);   // illegal digit ignored
    tbl[8] = mk(2, 0, 9, 0, 9, 0);    // leading zero
    for (int i = 0; i < 9; i++) begin
      begin_session();
      for (int j = 0; j < tbl[i].n; j++) key_digit(tbl[i].d[j]);
      chk($sformatf("vec%0d digit_count", i), digit_count, q.size());
      commit_and_check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ee);
    end

    // Backspace, including on an empty buffer, and start ignored in EDIT.
    begin_session();
    key_bs();
    chk("bs empty count", digit_count, 0);
    key_digit(1); key_digit(2); key_bs(); key_digit(7);
    chk("bs digits_out", digits_out, 8'h17);
    start = 1; cyc(); start = 0;
    chk("start in edit ignored", digit_count, 2);
    commit_and_check("backspace", 17, 0);

    // enter and cancel together: cancel wins.
    begin_session();
    key_digit(3);
    enter = 1;
    cancel_and_check("enter+cancel");
    seen = 0;
    for (int i = 0; i < 6; i++) begin cyc(); if (value_valid) seen = 1; end
    chk("no commit after cancel", seen, 0);

    // start while DONE is ignored, accepted on the following edge.
    begin_session();
    key_digit(1); key_digit(2);
    enter = 1; cyc(); enter = 0;
    cyc(); cyc(); cyc();
    start = 1; cyc();
    chk("done-cycle valid", value_valid, 1);
    chk("done-cycle value", value_out, 12);
    chk("start in done ignored", editing, 0);
    cyc(); start = 0;
    chk("start after done accepted", editing, 1);
    $display("[TB] start during DONE: ignored, then accepted");
    q.delete(); last_val = 12; last_err = 0;
    cancel_and_check("after restart");

    // Reset in the middle of a conversion.
    begin_session();
    key_digit(2); key_digit(0);
    enter = 1; cyc(); enter = 0;
    cyc();
    chk("mid convert busy", busy, 1);
    reset_n = 0; cyc();
    check_reset_state("mid-convert reset");
    reset_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin cyc(); if (value_valid) seen = 1; end
    chk("no commit after reset", seen, 0);
    $display("[TB] reset during CONVERT");
    last_val = 0; last_err = 0;
    begin_session();
    key_digit(4);
    commit_and_check("after reset", 4, 0);

    // Randomised sessions against the model, with random clamp bounds.
    for (int s = 0; s < 40; s++) begin
      min_value = 8'($urandom_range(0, 30));
      max_value = 8'($urandom_range(0, 60));
      cur_value = 8'($urandom_range(0, 255));
      begin_session();
      done = 0;
      for (int c = 0; c < 10 && !done; c++) begin
        cn = ($urandom_range(0, 19) == 0);
        en = ($urandom_range(0, 7) == 0);
        bs = ($urandom_range(0, 4) == 0);
        dv = ($urandom_range(0, 1) == 1);
        dd = $urandom_range(0, 11);
        backspace = bs; digit_valid = dv; digit = 4'(dd);
        if (cn) begin
          enter = en;
          cancel_and_check($sformatf("rand%0d", s));
          done = 1;
        end else if (en) begin
          model_result(ev_i, ee_i);
          commit_and_check($sformatf("rand%0d", s), ev_i, ee_i);
          done = 1;
        end else begin
          cyc(); idle_inputs();
          if (bs) model_bs();
          else if (dv) model_digit(dd);
          chk($sformatf("rand%0d digits_out", s), digits_out, model_digits());
          chk($sformatf("rand%0d digit_count", s), digit_count, q.size());
        end
      end
      if (!done) begin
        model_result(ev_i, ee_i);
        commit_and_check($sformatf("rand%0d end", s), ev_i, ee_i);
      end
    end
`else
    // Filling the buffer commits without enter.
    begin_session();
    key_digit(1); key_digit(3);
    chk("auto busy", busy, 1);
    chk("auto editing", editing, 0);
    chk("auto digits_out", digits_out, 8'h13);
    wait_valid(lat_i);
    chk("auto latency", lat_i, 4);
    chk("auto value_out", value_out, 13);
    chk("auto range_err", range_err, 0);
    last_val = 13; last_err = 0;
    $display("[TB] autocommit: value=%0d latency=%0d", value_out, lat_i);
    cyc();

    // Autocommit clamps like an explicit enter.
    begin_session();
    key_digit(7); key_digit(0);
    wait_valid(lat_i);
    chk("auto clamp latency", lat_i, 4);
    chk("auto clamp value", value_out, 21);
    chk("auto clamp err", range_err, 1);
    last_val = 21; last_err = 1;
    $display("[TB] autocommit clamp: value=%0d", value_out);
    cyc();

    // Cancel in the first implicit-commit cycle still aborts.
    begin_session();
    key_digit(1); key_digit(9);
    cancel_and_check("auto cancel");
    seen = 0;
    for (int i = 0; i < 6; i++) begin cyc(); if (value_valid) seen = 1; end
    chk("no commit after auto cancel", seen, 0);

    // A partial buffer still needs enter.
    begin_session();
    key_digit(5);
    commit_and_check("auto single", 5, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decimal_value_entry.md
Name: decimal_value_entry

Overview:
- Inverse of the option decimalizer: turns a stream of decimal keystrokes (digits, backspace, enter, cancel) into a clamped binary option value.
- Sits between the keyboard/button decoder and the options-menu state update.
- Exposes the live digit buffer for on-screen echo while editing.
- Conversion is serial (Horner, one digit per clock).

Parameters:
W_OUT, 8, width of binary value ports
MAX_DIGITS, 2, digit buffer depth (1..4)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  begin edit session (honoured only in IDLE)
cur_value  in  W_OUT  value returned when enter is pressed with empty buffer
min_value  in  W_OUT  inclusive lower clamp
max_value  in  W_OUT  inclusive upper clamp
digit_valid  in  1  digit strobe
digit  in  4  digit code, 0..9 legal
backspace  in  1  delete last digit
enter  in  1  commit
cancel  in  1  abort session
editing  out  1  high in EDIT
busy  out  1  high in CONVERT/CHECK
digits_out  out  MAX_DIGITS x 4  packed buffer, [0] = least significant, unused slots 0
digit_count  out  3  digits held
value_out  out  W_OUT  committed value, held until next commit
value_valid  out  1  one-cycle commit pulse
range_err  out  1  set with value_valid when clamping occurred, held until next commit
cancelled  out  1  one-cycle abort pulse

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; all outputs 0; buffer cleared. Reset overrides any state, including mid-CONVERT.
- IDLE:
  - start -> EDIT; buffer and digit_count cleared.
  - All other inputs ignored.
- EDIT, per-cycle priority cancel > enter > backspace > digit_valid; lower-priority events in the same cycle are dropped.
  - digit_valid with digit<=9 and count<MAX_DIGITS: buffer shifts up, new digit enters at [0], count+1.
  - digit>9, or buffer full: ignored.
  - backspace: buffer shifts down, top slot zeroed, count-1; ignored if count=0.
  - cancel: -> IDLE; cancelled=1 for one cycle; value_out and range_err unchanged.
  - enter: -> CONVERT if count>0, else -> CHECK; accumulator cleared.
- CONVERT:
  - One digit per cycle, most significant first: acc = acc*10 + d.
  - acc is W_OUT+1 bits and saturates at all-ones.
  - After count cycles -> CHECK.
  - All inputs ignored.
- CHECK (1 cycle):
  - count=0: result = cur_value.
  - Otherwise: acc<min -> min, range_err=1; acc>max or saturated -> max, range_err=1; else acc, range_err=0.
  - Then -> DONE.
- DONE (1 cycle): value_out registered; value_valid=1; -> IDLE.
- Latency: enter sampled at edge k gives value_valid high at edge k+count+2, for every count including 0.
- min_value > max_value: the max clamp wins; the result equals max_value.
- start outside IDLE is ignored.
- start in the same cycle as value_valid is ignored (state is DONE, not IDLE); it is accepted one cycle later.

Optional Feature:
- Macro: DIGIT_ENTRY_AUTOCOMMIT_EN.
- Defined: a digit accepted that makes count reach MAX_DIGITS behaves as an implicit enter on the following cycle. State goes EDIT -> CONVERT without needing an enter strobe; any input in that cycle is ignored except cancel, which still aborts.
- Undefined: a full buffer waits for an explicit enter; extra digits are ignored.

Decomposition:
- Shared package:
  - DE_STATE enum {DE_IDLE, DE_EDIT, DE_CONVERT, DE_CHECK, DE_DONE}.
  - Digit-buffer packed typedef parameterised by MAX_DIGITS.
  - Decimal base constant 10.
  - powers_of_10 table, reused for MAX_DIGITS-based saturation limits.
- Sub-module dec_mac_sat: combinational acc*10+d, computed as (acc<<3)+(acc<<1)+d, with saturation flag. Instantiated once in the CONVERT datapath.

Test Plan:
All cases use W_OUT=8, MAX_DIGITS=2, min=1, max=21, cur_value=6.
- Plain commit: start; digits 1,5; enter -> value_out=15, range_err=0, value_valid exactly 4 cycles after enter edge, digits_out={1,5} while editing.
- Clamp high and full buffer: start; digits 9,9,3 -> third digit ignored, count=2; enter -> value_out=21, range_err=1.
- Clamp low and empty commit: digits 0; enter -> 1, range_err=1. Separately, start then enter with empty buffer -> value_out=6, valid 2 cycles after enter.
- Backspace and priority: digits 1,2; backspace; 7 -> digits_out={1,7}; enter -> 17. Separately, same-cycle enter+cancel -> cancelled pulse, no value_valid, value_out keeps 17.
- Reset mid-operation: digits 2,0; enter; assert reset_n=0 during CONVERT -> all outputs 0, state IDLE, no value_valid. Next session with digits 4 -> 4.
- DIGIT_ENTRY_AUTOCOMMIT_EN defined: start; digits 1,3, no enter -> value_valid with value_out=13, 4 cycles after the second digit's edge.
